// File: rtl/softmax_ctrl.sv
// softmax_ctrl: sequencer around the 10-way softmax unit.
// Accepts a logit vector, runs the softmax unit until it acknowledges, captures
// the probabilities, and scans them for the argmax class. It then holds the
// result until downstream accepts it. Between jobs, enable is held low long
// enough for the unit to reset itself. A stuck job is abandoned after TIMEOUT
// cycles.
module softmax_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023,
    parameter int CLR_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH*10-1:0] in_data,
    output logic                     sm_enable,
    output logic [DATA_WIDTH*10-1:0] sm_inputs,
    input  logic [DATA_WIDTH*10-1:0] sm_outputs,
    input  logic                     sm_ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH*10-1:0] out_data,
    output logic [3:0]               out_class,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int VW = DATA_WIDTH * 10;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RUN,
        S_SCAN,
        S_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              clr_cnt_q, clr_cnt_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic [3:0]              scan_idx_q, scan_idx_d;
    logic [DATA_WIDTH-2:0]   best_val_q, best_val_d;
    logic [3:0]              best_idx_q, best_idx_d;
    logic [VW-1:0]           sm_inputs_q, sm_inputs_d;
    logic [VW-1:0]           out_data_q, out_data_d;
    logic [3:0]              out_class_q, out_class_d;
    logic                    timeout_err_q, timeout_err_d;
    logic                    sm_enable_q, sm_enable_d;
    logic [DATA_WIDTH-2:0]   scan_mag;
    logic                    take_new;

    // Select the magnitude (sign bit dropped) of the element under scan, so -0.0 compares as 0.0
    always_comb begin
        scan_mag = '0;
        for (int i = 0; i < 10; i++) begin
            if (scan_idx_q == 4'(i)) begin
                scan_mag = out_data_q[i*DATA_WIDTH +: DATA_WIDTH-1];
            end
        end
    end

    // Next-state logic: handshake, softmax run with timeout, argmax scan, result hold
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        scan_idx_d    = scan_idx_q;
        best_val_d    = best_val_q;
        best_idx_d    = best_idx_q;
        sm_inputs_d   = sm_inputs_q;
        out_data_d    = out_data_q;
        out_class_d   = out_class_q;
        timeout_err_d = timeout_err_q;
        take_new      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                if (clr_cnt_q == 4'(CLR_CYCLES - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    sm_inputs_d   = in_data;
                    tmo_cnt_d     = '0;
                    timeout_err_d = 1'b0;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                if (sm_ack) begin
                    out_data_d = sm_outputs;
                    scan_idx_d = '0;
                    state_d    = S_SCAN;
                end else if (TIMEOUT != 0 && tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    clr_cnt_d     = '0;
                    state_d       = S_CLEAR;
                end else if (tmo_cnt_q != TW'(TIMEOUT)) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_SCAN: begin
                take_new = (scan_idx_q == 4'd0) || (scan_mag > best_val_q);
                if (take_new) begin
                    best_val_d = scan_mag;
                    best_idx_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + 4'd1;
                if (scan_idx_q == 4'd9) begin
                    out_class_d = take_new ? scan_idx_q : best_idx_q;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    clr_cnt_d = '0;
                    state_d   = S_CLEAR;
                end
            end
            default: begin
                clr_cnt_d = '0;
                state_d   = S_CLEAR;
            end
        endcase
        sm_enable_d = (state_d == S_RUN);
    end

    // State and datapath registers; reset drops enable at once and restarts in CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_CLEAR;
            clr_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            scan_idx_q    <= '0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            sm_inputs_q   <= '0;
            out_data_q    <= '0;
            out_class_q   <= '0;
            timeout_err_q <= 1'b0;
            sm_enable_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            scan_idx_q    <= scan_idx_d;
            best_val_q    <= best_val_d;
            best_idx_q    <= best_idx_d;
            sm_inputs_q   <= sm_inputs_d;
            out_data_q    <= out_data_d;
            out_class_q   <= out_class_d;
            timeout_err_q <= timeout_err_d;
            sm_enable_q   <= sm_enable_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign busy        = (state_q != S_IDLE);
    assign sm_enable   = sm_enable_q;
    assign sm_inputs   = sm_inputs_q;
    assign out_data    = out_data_q;
    assign out_class   = out_class_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_softmax_ctrl.sv
// tb_softmax_ctrl: directed bench for softmax_ctrl with a behavioural softmax model.
module tb_softmax_ctrl;

    localparam int VW = 320;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [VW-1:0] inData = '0;
    logic          smEnable;
    logic [VW-1:0] smInputs;
    logic [VW-1:0] smOutputs = '0;
    logic          smAck = 1'b0;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [VW-1:0] outData;
    logic [3:0]    outClass;
    logic          busy;
    logic          timeoutErr;

    logic          tInValid = 1'b0;
    logic          tInReady;
    logic          tSmEnable;
    logic [VW-1:0] tSmInputs;
    logic [VW-1:0] tSmOutputs = '0;
    logic          tSmAck = 1'b0;
    logic          tOutValid;
    logic          tOutReady = 1'b0;
    logic [VW-1:0] tOutData;
    logic [3:0]    tOutClass;
    logic          tBusy;
    logic          tTimeoutErr;

    logic [VW-1:0] modelOut = '0;
    int            modelDelay = 0;
    int            modelCnt = 0;
    int            enLowNegs = 0;

    int testsRun = 0;
    int testsFailed = 0;

    softmax_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .sm_enable(smEnable), .sm_inputs(smInputs), .sm_outputs(smOutputs), .sm_ack(smAck),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_class(outClass),
        .busy(busy), .timeout_err(timeoutErr)
    );

    softmax_ctrl #(.TIMEOUT(16)) dutT (
        .clk(clk), .rst_n(rst_n), .in_valid(tInValid), .in_ready(tInReady), .in_data(320'h1234),
        .sm_enable(tSmEnable), .sm_inputs(tSmInputs), .sm_outputs(tSmOutputs), .sm_ack(tSmAck),
        .out_valid(tOutValid), .out_ready(tOutReady), .out_data(tOutData), .out_class(tOutClass),
        .busy(tBusy), .timeout_err(tTimeoutErr)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Softmax unit model: works on negedge, resets while enable is low, acks modelDelay cycles after enable
    always @(negedge clk) begin
        if (!smEnable) begin
            modelCnt = 0;
            smAck = 1'b0;
            smOutputs = '0;
            enLowNegs++;
        end else begin
            modelCnt++;
            if (modelDelay > 0 && modelCnt >= modelDelay) begin
                smAck = 1'b1;
                smOutputs = modelOut;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] mkVec(input logic [31:0] base, input int ia, input logic [31:0] va,
                                            input int ib, input logic [31:0] vb);
        logic [VW-1:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = (i == ia) ? va : ((i == ib) ? vb : base);
        return v;
    endfunction

    // One job on the main DUT up to the point where out_valid is seen; out_ready is left to the caller
    task automatic doJob(input logic [VW-1:0] vec, input logic [VW-1:0] mvec, input int delay,
                         output int runCycles, output int scanTicks, output bit enInScan,
                         output bit inputsOk, output bit ok);
        runCycles = 0;
        scanTicks = 0;
        enInScan = 1'b0;
        inputsOk = 1'b1;
        modelOut = mvec;
        modelDelay = delay;
        for (int i = 0; i < 50 && !inReady; i++) tick();
        ok = inReady;
        if (!ok) return;
        inData = vec;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        while (smEnable && runCycles < 500) begin
            if (smInputs !== vec) inputsOk = 1'b0;
            runCycles++;
            tick();
        end
        while (!outValid && scanTicks < 50) begin
            if (smEnable) enInScan = 1'b1;
            scanTicks++;
            tick();
        end
        ok = outValid;
    endtask

    task automatic test_reset();
        testsRun++;
        if ({busy, inReady, smEnable, outValid, timeoutErr, outClass} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_ctrl: busy/rdy/en/vld/err/cls=%b required 100000000", {busy, inReady, smEnable, outValid, timeoutErr, outClass});
        end
        testsRun++;
        if ({smInputs, outData} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: sm_inputs=%h out_data=%h required 0", smInputs, outData);
        end
        rst_n = 1'b1;
        inData = mkVec(32'h11111111, -1, 0, -1, 0);
        inValid = 1'b1;
        tick();
        testsRun++;
        if (inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_clear_1: in_ready=%b required 0", inReady);
        end
        tick();
        inValid = 1'b0;
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_clear_2: in_ready=%b required 1", inReady);
        end
        tick();
        testsRun++;
        if (smEnable !== 1'b0 || smInputs !== '0) begin
            testsFailed++;
            $display("[TB] FAIL no_capture: sm_enable=%b sm_inputs=%h required 0/0", smEnable, smInputs);
        end
    endtask

    task automatic test_basic();
        int rc, st;
        bit en, inOk, ok;
        logic [VW-1:0] mv;
        mv = mkVec(32'h3D638E39, 3, 32'h3F000000, -1, 0);
        doJob(mkVec(32'h3F800000, 3, 32'h40400000, -1, 0), mv, 40, rc, st, en, inOk, ok);
        testsRun++;
        if (!ok || rc != 40 || st != 10) begin
            testsFailed++;
            $display("[TB] FAIL basic_timing: ok=%0d run=%0d scan=%0d required 1/40/10", ok, rc, st);
        end
        testsRun++;
        if (en || !inOk) begin
            testsFailed++;
            $display("[TB] FAIL basic_enable: en_in_scan=%0d inputs_ok=%0d required 0/1", en, inOk);
        end
        testsRun++;
        if (outData !== mv || outClass !== 4'd3) begin
            testsFailed++;
            $display("[TB] FAIL basic_result: class=%0d data=%h required 3 %h", outClass, outData, mv);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        testsRun++;
        if (outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_release: out_valid=%b required 0", outValid);
        end
    endtask

    task automatic test_tie();
        int rc, st;
        bit en, inOk, ok;
        logic [VW-1:0] mv;
        mv = mkVec(32'h3D000000, 2, 32'h3E800000, 7, 32'h3E800000);
        doJob(mkVec(32'h3F000000, 7, 32'h3F800000, -1, 0), mv, 12, rc, st, en, inOk, ok);
        testsRun++;
        if (!ok || outClass !== 4'd2 || outData !== mv) begin
            testsFailed++;
            $display("[TB] FAIL tie_class: ok=%0d class=%0d required 1/2", ok, outClass);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_backpressure();
        int rc, st, bad;
        bit en, inOk, ok;
        logic [VW-1:0] mv;
        mv = mkVec(32'h3D000000, 9, 32'h3F000000, -1, 0);
        doJob(mkVec(32'h3E000000, 0, 32'h3E100000, -1, 0), mv, 8, rc, st, en, inOk, ok);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (outValid !== 1'b1 || outData !== mv || outClass !== 4'd9 || inReady !== 1'b0 || smEnable !== 1'b0) bad++;
            tick();
        end
        testsRun++;
        if (!ok || bad != 0) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold: ok=%0d unstable_cycles=%0d class=%0d required 1/0/9", ok, bad, outClass);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        testsRun++;
        if (outValid !== 1'b0 || busy !== 1'b1 || inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_handshake: vld/busy/rdy=%b%b%b required 010", outValid, busy, inReady);
        end
        tick();
        testsRun++;
        if (inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_clear: in_ready=%b required 0", inReady);
        end
        tick();
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_idle: in_ready=%b required 1", inReady);
        end
    endtask

    task automatic test_timeout();
        int rc, sawValid;
        logic [VW-1:0] tv;
        for (int i = 0; i < 50 && !tInReady; i++) tick();
        tInValid = 1'b1;
        tick();
        tInValid = 1'b0;
        rc = 0;
        sawValid = 0;
        while (tSmEnable && rc < 100) begin
            if (tOutValid) sawValid++;
            rc++;
            tick();
        end
        testsRun++;
        if (rc != 16 || tTimeoutErr !== 1'b1 || tSmEnable !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_fire: run=%0d err=%b en=%b required 16/1/0", rc, tTimeoutErr, tSmEnable);
        end
        for (int i = 0; i < 6; i++) begin
            if (tOutValid) sawValid++;
            tick();
        end
        testsRun++;
        if (sawValid != 0 || tOutData !== '0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_noresult: valid_cycles=%0d out_data=%h required 0/0", sawValid, tOutData);
        end
        for (int i = 0; i < 50 && !tInReady; i++) tick();
        tInValid = 1'b1;
        tick();
        tInValid = 1'b0;
        testsRun++;
        if (tTimeoutErr !== 1'b0 || tSmEnable !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL timeout_clear: err=%b en=%b required 0/1", tTimeoutErr, tSmEnable);
        end
        tick();
        tv = mkVec(32'h3D800000, 6, 32'h3F400000, -1, 0);
        tSmOutputs = tv;
        tSmAck = 1'b1;
        tick();
        tSmAck = 1'b0;
        for (int i = 0; i < 20 && !tOutValid; i++) tick();
        testsRun++;
        if (tOutValid !== 1'b1 || tOutClass !== 4'd6 || tOutData !== tv || tTimeoutErr !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL timeout_nextjob: vld=%b class=%0d err=%b required 1/6/0", tOutValid, tOutClass, tTimeoutErr);
        end
        tOutReady = 1'b1;
        tick();
        tOutReady = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int rc, st;
        bit en, inOk, ok;
        logic [VW-1:0] mv;
        modelDelay = 40;
        for (int i = 0; i < 50 && !inReady; i++) tick();
        inData = mkVec(32'h3F800000, 5, 32'h40000000, -1, 0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        testsRun++;
        if (smEnable !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrun_pre: sm_enable=%b required 1", smEnable);
        end
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({smEnable, inReady, outValid, busy, timeoutErr, outClass} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0} ||
            smInputs !== '0 || outData !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_reset: en/rdy/vld/busy/err/cls=%b sm_inputs=%h required 000100000 and 0",
                     {smEnable, inReady, outValid, busy, timeoutErr, outClass}, smInputs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        testsRun++;
        if (inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_clear: in_ready=%b required 0", inReady);
        end
        tick();
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrun_idle: in_ready=%b required 1", inReady);
        end
        mv = mkVec(32'h3D000000, 1, 32'h3F000000, -1, 0);
        doJob(mkVec(32'h3F000000, 1, 32'h3F800000, -1, 0), mv, 6, rc, st, en, inOk, ok);
        testsRun++;
        if (!ok || outClass !== 4'd1 || outData !== mv || rc != 6) begin
            testsFailed++;
            $display("[TB] FAIL midrun_fresh: ok=%0d class=%0d run=%0d required 1/1/6", ok, outClass, rc);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] inVecs[3];
        logic [VW-1:0] mVecs[3];
        logic [3:0]    expCls[3];
        int acc, res, t, lastValidT, enLowAtValid;
        logic prevEn;
        inVecs[0] = mkVec(32'h3F800000, -1, 0, -1, 0);
        inVecs[1] = mkVec(32'h3F000000, 4, 32'h40000000, -1, 0);
        inVecs[2] = mkVec(32'h3E000000, 6, 32'h3F800000, -1, 0);
        mVecs[0]  = mkVec(32'h3DCCCCCD, -1, 0, -1, 0);
        mVecs[1]  = mkVec(32'h3E000000, 4, 32'hBF800000, 1, 32'h80000000);
        mVecs[2]  = mkVec(32'h3D800000, 6, 32'h3F400000, -1, 0);
        expCls[0] = 4'd0;
        expCls[1] = 4'd4;
        expCls[2] = 4'd6;
        modelDelay = 5;
        outReady = 1'b1;
        inData = inVecs[0];
        inValid = 1'b1;
        acc = 0;
        res = 0;
        lastValidT = 0;
        enLowAtValid = 0;
        prevEn = smEnable;
        for (t = 1; t < 400 && res < 3; t++) begin
            tick();
            if (smEnable && !prevEn && acc < 3) begin
                modelOut = mVecs[acc];
                testsRun++;
                if (smInputs !== inVecs[acc]) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_accept%0d: sm_inputs=%h required %h", acc, smInputs, inVecs[acc]);
                end
                if (acc > 0) begin
                    testsRun++;
                    if (t - lastValidT != 4 || enLowNegs - enLowAtValid < 1) begin
                        testsFailed++;
                        $display("[TB] FAIL b2b_gap%0d: gap=%0d low_negedges=%0d required 4 and >=1",
                                 acc, t - lastValidT, enLowNegs - enLowAtValid);
                    end
                end
                acc++;
                if (acc < 3) inData = inVecs[acc];
                else inValid = 1'b0;
            end
            if (outValid) begin
                testsRun++;
                if (outClass !== expCls[res] || outData !== mVecs[res]) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_result%0d: class=%0d required %0d", res, outClass, expCls[res]);
                end
                res++;
                lastValidT = t;
                enLowAtValid = enLowNegs;
            end
            prevEn = smEnable;
        end
        inValid = 1'b0;
        outReady = 1'b0;
        testsRun++;
        if (res != 3 || acc != 3) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count: results=%0d accepts=%0d required 3/3", res, acc);
        end
    endtask

    // Scenario sequence
    initial begin
        tick();
        tick();
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
